rename_queue: RTL and testbench

- 2-wide in-order FIFO between the decoder and the renamer.
- Buffers decoded instruction records (address, immediate, instr_name, instr_type, regs, flags) so decoder stalls are decoupled from rename stalls.
- Supports speculative squash: on the ROB's delete_tagged pulse it discards entries fetched after an unresolved branch; on clear_tags it commits them.
- Exposes its occupancy to the debug interface as ren_queue_size.

---
 rtl/rename_queue_pkg.sv | 53 +++++
 rtl/rename_queue_if.sv | 22 ++
 rtl/rename_queue_mem.sv | 38 +++
 rtl/rename_queue.sv | 146 ++++++++++++++
 tb/tb_rename_queue.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_queue_pkg.sv
// rename_queue_pkg: decode record types shared by the decoder, rename queue and renamer,
// plus the rename queue sizing constants.
package rename_queue_pkg;

  localparam int CPU_XLEN        = 32;
  localparam int REN_QUEUE_DEPTH = 64;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_ADD    = 4'd1,
    I_SUB    = 4'd2,
    I_LOAD   = 4'd3,
    I_STORE  = 4'd4,
    I_BRANCH = 4'd5,
    I_JAL    = 4'd6,
    I_LUI    = 4'd7
  } instr_name_e;

  typedef enum logic [1:0] {
    T_ALU    = 2'd0,
    T_MEM    = 2'd1,
    T_BRANCH = 2'd2,
    T_SYS    = 2'd3
  } instr_type_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } src_dest_t;

  // tag marks an entry fetched under a still-unresolved branch
  typedef struct packed {
    logic uses_imm;
    logic is_branch;
    logic illegal;
    logic tag;
  } flag_vector_t;

  typedef struct packed {
    logic [CPU_XLEN-1:0] address;
    logic [CPU_XLEN-1:0] immediate;
    instr_name_e         instr_name;
    instr_type_e         instr_type;
    src_dest_t           regs;
    flag_vector_t        flags;
  } queue_entry_t;

  function automatic logic [1:0] pop2(input logic [1:0] v);
    return 2'(v[0]) + 2'(v[1]);
  endfunction

endpackage

// File: rtl/rename_queue_if.sv
// rename_queue_if: decoder-side enqueue and renamer-side dequeue handshake of rename_queue.
interface rename_queue_if;
  import rename_queue_pkg::*;

  logic [1:0]         in_valid;
  queue_entry_t [1:0] in_entry;
  logic               in_ready;
  logic [1:0]         out_valid;
  queue_entry_t [1:0] out_entry;
  logic [1:0]         out_take;

  modport master (
    output in_valid, in_entry, out_take,
    input  in_ready, out_valid, out_entry
  );

  modport slave (
    input  in_valid, in_entry, out_take,
    output in_ready, out_valid, out_entry
  );

endinterface

// File: rtl/rename_queue_mem.sv
// rename_queue_mem: 2-write/2-read entry array with a global tag-clear strobe.
// No reset: contents are only meaningful between head and tail of the owning queue.
module rename_queue_mem
  import rename_queue_pkg::*;
#(
  parameter int DEPTH = REN_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] waddr0,
  input  logic [$clog2(DEPTH)-1:0] waddr1,
  input  queue_entry_t             wdata0,
  input  queue_entry_t             wdata1,
  input  logic                     tag_clr,
  input  logic [$clog2(DEPTH)-1:0] raddr0,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output queue_entry_t             rdata0,
  output queue_entry_t             rdata1
);

  queue_entry_t mem [DEPTH];

  // New writes land after the clear so they keep their own (already untagged) value
  always_ff @(posedge clk) begin
    if (tag_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].flags.tag <= 1'b0;
      end
    end
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/rename_queue.sv
// rename_queue: 2-wide in-order FIFO between decoder and renamer with speculative squash/commit.
// Optional same-cycle bypass while empty is enabled by defining RENAME_QUEUE_BYPASS_EN.
module rename_queue
  import rename_queue_pkg::*;
#(
  parameter int DEPTH = REN_QUEUE_DEPTH,
  parameter int XLEN  = CPU_XLEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   delete_tagged,
  input  logic                   clear_tags,
  rename_queue_if.slave          q,
  output logic [$clog2(DEPTH):0] ren_queue_size
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] READY_MAX = PW'(DEPTH - 2);

  if (XLEN != CPU_XLEN) begin : g_xlen_check
    $error("rename_queue: XLEN must match CPU_XLEN of queue_entry_t");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("rename_queue: DEPTH must be a power of two and at least 4");
  end

  logic [PW-1:0] head, tail, tcount;
  logic [PW-1:0] count, untagged, deq_tag, tcount_post, base;
  logic [PW-1:0] w_tagged;
  logic          rdy, enq, tag_clr;
  logic [1:0]    stk, byp_take, wn;
  logic          we0, we1;
  logic [AW-1:0] waddr0, waddr1, raddr0, raddr1;
  queue_entry_t  rd0, rd1;
  queue_entry_t  s0, s1, c_ent0, c_ent1, w_ent0, w_ent1;
  logic          k0, k1;
  logic [1:0]    c_vld;

  assign count          = tail - head;
  assign rdy            = (count <= READY_MAX);
  assign enq            = rdy & (|q.in_valid);
  assign q.in_ready     = rdy;
  assign ren_queue_size = count;

  // Incoming pair after squash/commit filtering, compacted so valid is 00, 01 or 11
  always_comb begin
    s0 = q.in_entry[0];
    s1 = q.in_entry[1];
    if (!delete_tagged && clear_tags) begin
      s0.flags.tag = 1'b0;
      s1.flags.tag = 1'b0;
    end
    k0     = enq & q.in_valid[0] & ~(delete_tagged & s0.flags.tag);
    k1     = enq & q.in_valid[1] & ~(delete_tagged & s1.flags.tag);
    c_vld  = 2'b00;
    c_ent0 = s0;
    c_ent1 = s1;
    if (k0) begin
      c_vld = k1 ? 2'b11 : 2'b01;
    end else if (k1) begin
      c_vld  = 2'b01;
      c_ent0 = s1;
    end
  end

  // Take from storage when non-empty; an illegal take leaves the pointers alone
  always_comb begin
    stk      = 2'd0;
    byp_take = 2'd0;
    if (count != '0) begin
      if (q.out_take != 2'd3 && PW'(q.out_take) <= count) stk = q.out_take;
    end
`ifdef RENAME_QUEUE_BYPASS_EN
    else if (q.out_take <= pop2(c_vld)) begin
      byp_take = q.out_take;
    end
`endif
  end

  always_comb begin
    q.out_valid    = {count >= PW'(2), count >= PW'(1)};
    q.out_entry[0] = rd0;
    q.out_entry[1] = rd1;
`ifdef RENAME_QUEUE_BYPASS_EN
    if (count == '0) begin
      q.out_valid    = c_vld;
      q.out_entry[0] = c_ent0;
      q.out_entry[1] = c_ent1;
    end
`endif
  end

  // Tagged entries are the youngest suffix, so dequeued tags are whatever exceeds the untagged prefix
  assign untagged    = count - tcount;
  assign deq_tag     = (PW'(stk) > untagged) ? (PW'(stk) - untagged) : '0;
  assign tcount_post = tcount - deq_tag;
  assign base        = delete_tagged ? (tail - tcount_post) : tail;

  assign wn       = pop2(c_vld) - byp_take;
  assign we0      = (wn != 2'd0);
  assign we1      = (wn == 2'd2);
  assign w_ent0   = (byp_take == 2'd1) ? c_ent1 : c_ent0;
  assign w_ent1   = c_ent1;
  assign w_tagged = PW'(we0 & w_ent0.flags.tag) + PW'(we1 & w_ent1.flags.tag);
  assign tag_clr  = clear_tags & ~delete_tagged;

  assign waddr0 = base[AW-1:0];
  assign waddr1 = base[AW-1:0] + AW'(1);
  assign raddr0 = head[AW-1:0];
  assign raddr1 = head[AW-1:0] + AW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head   <= '0;
      tail   <= '0;
      tcount <= '0;
    end else begin
      head   <= head + PW'(stk);
      tail   <= base + PW'(wn);
      tcount <= (delete_tagged | clear_tags) ? '0 : (tcount_post + w_tagged);
    end
  end

  rename_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we0     (we0),
    .we1     (we1),
    .waddr0  (waddr0),
    .waddr1  (waddr1),
    .wdata0  (w_ent0),
    .wdata1  (w_ent1),
    .tag_clr (tag_clr),
    .raddr0  (raddr0),
    .raddr1  (raddr1),
    .rdata0  (rd0),
    .rdata1  (rd1)
  );

  a_take_legal: assert property (@(posedge clk) disable iff (!reset)
    q.out_take <= pop2(q.out_valid));

  a_in_valid_legal: assert property (@(posedge clk) disable iff (!reset)
    q.in_valid != 2'b10);

endmodule

// File: tb/tb_rename_queue.sv
// tb_rename_queue: table vectors, hand sequences and randomized traffic against a queue-based model.
module tb_rename_queue;
  import rename_queue_pkg::*;

  localparam int DEPTH = 64;

  typedef struct {
    logic [1:0] v;
    logic       t0;
    logic       t1;
    logic [1:0] tk;
    logic       d;
    logic       c;
    logic [6:0] exp_size;
    logic [1:0] exp_vld;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       del = 1'b0;
  logic       clr = 1'b0;
  logic [6:0] size;

  rename_queue_if rq();

  rename_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .delete_tagged  (del),
    .clear_tags     (clr),
    .q              (rq),
    .ren_queue_size (size)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int seq = 1000;
  bit rec = 1'b0;

  queue_entry_t mq[$];
  queue_entry_t inc[$];
  queue_entry_t pres[$];
  int           got[$];
  logic [1:0]   cur_tk;
  logic         cur_d, cur_c;
  queue_entry_t z = '0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic queue_entry_t mk(input int idx, input logic tag);
    queue_entry_t e;
    e.address         = 32'(idx * 4);
    e.immediate       = $urandom;
    e.instr_name      = instr_name_e'(4'($urandom_range(0, 7)));
    e.instr_type      = instr_type_e'(2'($urandom_range(0, 3)));
    e.regs.rs1        = 5'($urandom_range(0, 31));
    e.regs.rs2        = 5'($urandom_range(0, 31));
    e.regs.rd         = 5'($urandom_range(0, 31));
    e.flags.uses_imm  = 1'($urandom_range(0, 1));
    e.flags.is_branch = 1'($urandom_range(0, 1));
    e.flags.illegal   = 1'($urandom_range(0, 1));
    e.flags.tag       = tag;
    return e;
  endfunction

  // Entries that would be accepted this cycle, in order, after squash/commit filtering
  task automatic build_inc(input logic [1:0] v, input queue_entry_t e0, input queue_entry_t e1,
                           input logic d, input logic c);
    queue_entry_t e;
    inc.delete();
    if ((DEPTH - mq.size()) >= 2) begin
      for (int s = 0; s < 2; s++) begin
        if (v[s]) begin
          e = (s == 0) ? e0 : e1;
          if (d && e.flags.tag) continue;
          if (!d && c) e.flags.tag = 1'b0;
          inc.push_back(e);
        end
      end
    end
  endtask

  function automatic int avail();
    if (mq.size() > 0) return (mq.size() >= 2) ? 2 : 1;
`ifdef RENAME_QUEUE_BYPASS_EN
    return inc.size();
`else
    return 0;
`endif
  endfunction

  task automatic apply(input logic [1:0] v, input queue_entry_t e0, input queue_entry_t e1,
                       input logic [1:0] tk, input logic d, input logic c);
    logic [1:0] ev;
    @(negedge clk);
    rq.in_valid    = v;
    rq.in_entry[0] = e0;
    rq.in_entry[1] = e1;
    rq.out_take    = tk;
    del            = d;
    clr            = c;
    cur_tk         = tk;
    cur_d          = d;
    cur_c          = c;
    #1;
    build_inc(v, e0, e1, d, c);
    pres.delete();
    if (mq.size() > 0) begin
      for (int i = 0; i < mq.size() && i < 2; i++) pres.push_back(mq[i]);
    end
`ifdef RENAME_QUEUE_BYPASS_EN
    else pres = inc;
`endif
    ev = (pres.size() >= 2) ? 2'b11 : (pres.size() == 1) ? 2'b01 : 2'b00;
    check("out_valid", 128'(rq.out_valid), 128'(ev));
    check("in_ready", 128'(rq.in_ready), 128'((DEPTH - mq.size()) >= 2));
    check("ren_queue_size", 128'(size), 128'(mq.size()));
    for (int i = 0; i < pres.size(); i++)
      check($sformatf("out_entry%0d", i), 128'(rq.out_entry[i]), 128'(pres[i]));
    if (rec) begin
      for (int i = 0; i < int'(tk); i++) got.push_back(int'(rq.out_entry[i].address));
    end
  endtask

  task automatic update();
    int nb;
    nb = 0;
    if (mq.size() > 0) begin
      repeat (int'(cur_tk)) void'(mq.pop_front());
    end else begin
      nb = int'(cur_tk);
    end
    if (cur_d) begin
      while (mq.size() > 0 && mq[$].flags.tag) void'(mq.pop_back());
    end else if (cur_c) begin
      foreach (mq[i]) mq[i].flags.tag = 1'b0;
    end
    foreach (inc[i]) if (i >= nb) mq.push_back(inc[i]);
  endtask

  task automatic cyc(input logic [1:0] v, input queue_entry_t e0, input queue_entry_t e1,
                     input logic [1:0] tk, input logic d, input logic c);
    apply(v, e0, e1, tk, d, c);
    update();
  endtask

  task automatic drain();
    while (mq.size() > 0) cyc(2'b00, z, z, (mq.size() >= 2) ? 2'd2 : 2'd1, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [7];
    int         sent, ok_cnt, base_idx, iter, bound;
    logic [1:0] v, tk;
    logic       t0, t1, d, c, spec;
    queue_entry_t e0, e1;

    rq.in_valid = 2'b00;
    rq.in_entry = '0;
    rq.out_take = 2'b00;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 128'(rq.out_valid), 128'(2'b00));
    check("rst_size", 128'(size), 128'(0));
    check("rst_in_ready", 128'(rq.in_ready), 128'(1));
    @(negedge clk);
    reset = 1'b1;

    // Ordering and wrap: 200 untagged instructions, random enqueue/take
    rec  = 1'b1;
    sent = 0;
    iter = 0;
    while ((sent < 200 || mq.size() > 0) && iter < 3000) begin
      iter++;
      if (sent >= 200)      v = 2'b00;
      else if (sent == 199) v = 2'($urandom_range(0, 1));
      else begin
        v = 2'($urandom_range(0, 2));
        if (v == 2'b10) v = 2'b11;
      end
      e0 = mk(sent, 1'b0);
      e1 = mk(sent + 1, 1'b0);
      build_inc(v, e0, e1, 1'b0, 1'b0);
      bound = avail();
      tk = 2'($urandom_range(0, bound));
      apply(v, e0, e1, tk, 1'b0, 1'b0);
      sent += inc.size();
      update();
    end
    rec = 1'b0;
    check("order_count", 128'(got.size()), 128'(200));
    ok_cnt = 0;
    foreach (got[i]) if (got[i] == i * 4) ok_cnt++;
    check("order_sequence", 128'(ok_cnt), 128'(200));

    // Fill to full, one blocked pair, then take two
    for (int i = 0; i < 32; i++) begin
      cyc(2'b11, mk(seq, 1'b0), mk(seq + 1, 1'b0), 2'd0, 1'b0, 1'b0);
      seq += 2;
    end
    apply(2'b11, mk(seq, 1'b0), mk(seq + 1, 1'b0), 2'd0, 1'b0, 1'b0);
    seq += 2;
    check("full_size", 128'(size), 128'(64));
    check("full_in_ready", 128'(rq.in_ready), 128'(0));
    update();
    apply(2'b00, z, z, 2'd2, 1'b0, 1'b0);
    check("full_blocked_size", 128'(size), 128'(64));
    update();
    apply(2'b00, z, z, 2'd0, 1'b0, 1'b0);
    check("after_take_in_ready", 128'(rq.in_ready), 128'(1));
    check("after_take_size", 128'(size), 128'(62));
    update();
    drain();

    // Asynchronous reset in the middle of operation
    for (int i = 0; i < 5; i++) begin
      cyc(2'b11, mk(seq, 1'b0), mk(seq + 1, 1'b0), 2'd0, 1'b0, 1'b0);
      seq += 2;
    end
    @(negedge clk);
    rq.in_valid = 2'b00;
    rq.out_take = 2'b00;
    #1;
    check("pre_reset_size", 128'(size), 128'(10));
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_out_valid", 128'(rq.out_valid), 128'(2'b00));
    check("async_rst_size", 128'(size), 128'(0));
    check("async_rst_in_ready", 128'(rq.in_ready), 128'(1));
    mq.delete();
    @(negedge clk);
    reset = 1'b1;

    // Squash: 4 untagged + 6 tagged, delete_tagged with take 2
    tbl[0] = '{2'b11, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 7'd0, 2'b00};
`ifdef RENAME_QUEUE_BYPASS_EN
    tbl[0].exp_vld = 2'b11;
`endif
    tbl[1] = '{2'b11, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 7'd2,  2'b11};
    tbl[2] = '{2'b11, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 7'd4,  2'b11};
    tbl[3] = '{2'b11, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 7'd6,  2'b11};
    tbl[4] = '{2'b11, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 7'd8,  2'b11};
    tbl[5] = '{2'b00, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 7'd10, 2'b11};
    tbl[6] = '{2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 7'd2,  2'b11};
    base_idx = seq;
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].v, mk(seq, tbl[i].t0), mk(seq + 1, tbl[i].t1), tbl[i].tk, tbl[i].d, tbl[i].c);
      seq += 2;
      check($sformatf("tbl%0d_size", i), 128'(size), 128'(tbl[i].exp_size));
      check($sformatf("tbl%0d_out_valid", i), 128'(rq.out_valid), 128'(tbl[i].exp_vld));
      if (i == 6) begin
        check("squash_keep0_addr", 128'(rq.out_entry[0].address), 128'(32'((base_idx + 2) * 4)));
        check("squash_keep1_addr", 128'(rq.out_entry[1].address), 128'(32'((base_idx + 3) * 4)));
      end
      update();
    end
    drain();

    // Commit: 5 tagged entries, clear_tags then delete_tagged
    cyc(2'b11, mk(seq, 1'b1), mk(seq + 1, 1'b1), 2'd0, 1'b0, 1'b0);
    cyc(2'b11, mk(seq + 2, 1'b1), mk(seq + 3, 1'b1), 2'd0, 1'b0, 1'b0);
    cyc(2'b01, mk(seq + 4, 1'b1), z, 2'd0, 1'b0, 1'b0);
    seq += 6;
    cyc(2'b00, z, z, 2'd0, 1'b0, 1'b1);
    cyc(2'b00, z, z, 2'd0, 1'b1, 1'b0);
    apply(2'b00, z, z, 2'd0, 1'b0, 1'b0);
    check("commit_size", 128'(size), 128'(5));
    check("commit_tag0", 128'(rq.out_entry[0].flags.tag), 128'(0));
    check("commit_tag1", 128'(rq.out_entry[1].flags.tag), 128'(0));
    update();
    drain();

    // delete_tagged and clear_tags together: delete wins
    cyc(2'b11, mk(seq, 1'b1), mk(seq + 1, 1'b1), 2'd0, 1'b0, 1'b0);
    seq += 2;
    cyc(2'b00, z, z, 2'd0, 1'b1, 1'b1);
    apply(2'b00, z, z, 2'd0, 1'b0, 1'b0);
    check("del_wins_size", 128'(size), 128'(0));
    update();

    // Empty queue, pair arrives: bypass or one-cycle latency
    e0 = mk(seq, 1'b0);
    e1 = mk(seq + 1, 1'b0);
    seq += 2;
`ifdef RENAME_QUEUE_BYPASS_EN
    apply(2'b11, e0, e1, 2'd1, 1'b0, 1'b0);
    check("byp_out_valid", 128'(rq.out_valid), 128'(2'b11));
    check("byp_out_addr", 128'(rq.out_entry[0].address), 128'(e0.address));
    update();
    apply(2'b00, z, z, 2'd0, 1'b0, 1'b0);
    check("byp_next_size", 128'(size), 128'(1));
    check("byp_next_addr", 128'(rq.out_entry[0].address), 128'(e1.address));
    update();
`else
    apply(2'b11, e0, e1, 2'd0, 1'b0, 1'b0);
    check("latency_out_valid", 128'(rq.out_valid), 128'(2'b00));
    update();
    apply(2'b00, z, z, 2'd0, 1'b0, 1'b0);
    check("latency_next_size", 128'(size), 128'(2));
    check("latency_next_addr", 128'(rq.out_entry[0].address), 128'(e0.address));
    update();
`endif
    drain();

    // Random traffic with speculation, squash and commit
    spec = 1'b0;
    for (int n = 0; n < 500; n++) begin
      v = 2'($urandom_range(0, 2));
      if (v == 2'b10) v = 2'b11;
      if (spec) begin
        t0 = 1'b1;
        t1 = 1'b1;
      end else begin
        case ($urandom_range(0, 7))
          0:       begin t0 = 1'b1; t1 = 1'b1; spec = 1'b1; end
          1:       begin t0 = 1'b0; t1 = 1'b1; spec = 1'b1; end
          default: begin t0 = 1'b0; t1 = 1'b0; end
        endcase
      end
      d  = ($urandom_range(0, 15) == 0);
      c  = ($urandom_range(0, 15) == 0);
      e0 = mk(seq, t0);
      e1 = mk(seq + 1, t1);
      seq += 2;
      build_inc(v, e0, e1, d, c);
      bound = avail();
      tk = 2'($urandom_range(0, bound));
      cyc(v, e0, e1, tk, d, c);
      if (d || c) spec = 1'b0;
    end
    drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
